// File: rtl/row_bram_pkg.sv
// Shared types and constants for the LSB/MSB row BRAM pair.
// Tag struct follows each read through the BRAM latency.
package row_bram_pkg;

    localparam int ADDR_W = 10;
    localparam int ROW_W  = 1024;
    localparam int ROWS   = 768;
    localparam int PORT_W = 2;

    localparam int PORT_DISP   = 0;
    localparam int PORT_PLAYER = 1;
    localparam int PORT_SHADER = 2;

    typedef struct packed {
        logic              valid;
        logic [PORT_W-1:0] port;
        logic              oor;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Eligibility and round-robin pick among the non-display ports.
// Display override is applied by the caller through hold.
module rr_arbiter
    import row_bram_pkg::*;
#(
    parameter int              NREQ       = 3,
    parameter logic [NREQ-1:0] BLANK_MASK = 3'b110
) (
    input  logic            clk_65M,
    input  logic            clear,
    input  logic            blank,
    input  logic [NREQ-1:0] req,
    input  logic            hold,
    output logic            disp_elig,
    output logic [NREQ-1:0] gnt
);

    localparam int PTR_W = $clog2(NREQ);

    logic [NREQ-1:0]  elig;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] win;
    logic             found;
    int               idx;

    assign elig      = req & (~BLANK_MASK | {NREQ{blank}});
    assign disp_elig = elig[PORT_DISP];

    // scan the shared ports cyclically, starting just after rr_ptr
    always_comb begin
        gnt   = '0;
        win   = rr_ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k - 1) % (NREQ - 1) + PORT_PLAYER;
            if (!found && elig[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                win      = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge clk_65M or posedge clear) begin
        if (clear) begin
            rr_ptr <= PTR_W'(NREQ - 1);
        end else if (!hold && found) begin
            rr_ptr <= win;
        end
    end

endmodule

// File: rtl/row_read_arbiter.sv
// Shares the row BRAM read port among requesters, tags each read
// and routes the returned row to the port that issued it.
module row_read_arbiter #(
    parameter int              NREQ       = 3,
    parameter int              ADDR_W     = row_bram_pkg::ADDR_W,
    parameter int              ROW_W      = row_bram_pkg::ROW_W,
    parameter int              ROWS       = row_bram_pkg::ROWS,
    parameter int              RD_LATENCY = 2,
    parameter logic [NREQ-1:0] BLANK_MASK = 3'b110
) (
    input  logic                   clk_65M,
    input  logic                   clear,
    input  logic                   blank,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]        gnt,
    output logic [ADDR_W-1:0]      r_addr_lsb,
    output logic [ADDR_W-1:0]      r_addr_msb,
    output logic                   rd_en,
    input  logic [0:ROW_W-1]       r_data_lsb,
    input  logic [0:ROW_W-1]       r_data_msb,
    output logic [0:ROW_W-1]       rdata_lsb,
    output logic [0:ROW_W-1]       rdata_msb,
    output logic [NREQ-1:0]        rvalid,
    output logic                   err,
    output logic                   busy
);

    import row_bram_pkg::tag_t;
    import row_bram_pkg::PORT_W;

    logic [NREQ-1:0]   rr_gnt;
    logic              disp_elig;
    logic [ADDR_W-1:0] g_addr;
    logic [ADDR_W-1:0] r_addr;
    logic [PORT_W-1:0] g_port;
    logic              g_any;
    logic              g_oor;
    tag_t              tags [RD_LATENCY+1];
    tag_t              last;

    rr_arbiter #(
        .NREQ      (NREQ),
        .BLANK_MASK(BLANK_MASK)
    ) u_rr (
        .clk_65M  (clk_65M),
        .clear    (clear),
        .blank    (blank),
        .req      (req),
        .hold     (disp_elig),
        .disp_elig(disp_elig),
        .gnt      (rr_gnt)
    );

    always_comb begin
        priority case (1'b1)
            clear:     gnt = '0;
            disp_elig: gnt = NREQ'(1);
            default:   gnt = rr_gnt;
        endcase
    end

    always_comb begin
        g_addr = '0;
        g_port = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                g_addr = g_addr | req_addr[i*ADDR_W +: ADDR_W];
                g_port = PORT_W'(i);
            end
        end
    end

    assign g_any = |gnt;
    assign g_oor = {1'b0, g_addr} >= (ADDR_W+1)'(ROWS);

    always_ff @(posedge clk_65M or posedge clear) begin
        if (clear) begin
            r_addr <= '0;
            rd_en  <= 1'b0;
        end else begin
            rd_en <= g_any && !g_oor;
            if (g_any) r_addr <= g_addr;
        end
    end

    assign r_addr_lsb = r_addr;
    assign r_addr_msb = r_addr;

    // one stage per cycle of address-to-data latency, plus the issue stage
    always_ff @(posedge clk_65M or posedge clear) begin
        if (clear) begin
            for (int k = 0; k <= RD_LATENCY; k++) tags[k] <= '0;
        end else begin
            tags[0] <= '{valid: g_any, port: g_port, oor: g_oor};
            for (int k = 1; k <= RD_LATENCY; k++) tags[k] <= tags[k-1];
        end
    end

    assign last = tags[RD_LATENCY];

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k <= RD_LATENCY; k++) busy = busy | tags[k].valid;
    end

    always_ff @(posedge clk_65M or posedge clear) begin
        if (clear) begin
            rdata_lsb <= '0;
            rdata_msb <= '0;
            rvalid    <= '0;
            err       <= 1'b0;
        end else begin
            rvalid <= '0;
            err    <= 1'b0;
            if (last.valid) begin
                rvalid    <= NREQ'(1) << last.port;
                err       <= last.oor;
                rdata_lsb <= last.oor ? '0 : r_data_lsb;
                rdata_msb <= last.oor ? '0 : r_data_msb;
            end
        end
    end

endmodule

// File: tb/tb_row_read_arbiter.sv
// Randomized and directed bench for row_read_arbiter with a
// queue scoreboard and a behavioural BRAM/arbitration model.
module tb_row_read_arbiter;

    localparam int NREQ       = 3;
    localparam int ADDR_W     = 10;
    localparam int ROW_W      = 1024;
    localparam int ROWS       = 768;
    localparam int RD_LATENCY = 2;
    localparam logic [NREQ-1:0] MASK = 3'b110;

    logic                   clk_65M;
    logic                   clear;
    logic                   blank;
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]        gnt;
    logic [ADDR_W-1:0]      r_addr_lsb;
    logic [ADDR_W-1:0]      r_addr_msb;
    logic                   rd_en;
    logic [0:ROW_W-1]       r_data_lsb;
    logic [0:ROW_W-1]       r_data_msb;
    logic [0:ROW_W-1]       rdata_lsb;
    logic [0:ROW_W-1]       rdata_msb;
    logic [NREQ-1:0]        rvalid;
    logic                   err;
    logic                   busy;

    row_read_arbiter #(
        .NREQ      (NREQ),
        .RD_LATENCY(RD_LATENCY),
        .BLANK_MASK(MASK)
    ) dut (
        .clk_65M   (clk_65M),
        .clear     (clear),
        .blank     (blank),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .r_addr_lsb(r_addr_lsb),
        .r_addr_msb(r_addr_msb),
        .rd_en     (rd_en),
        .r_data_lsb(r_data_lsb),
        .r_data_msb(r_data_msb),
        .rdata_lsb (rdata_lsb),
        .rdata_msb (rdata_msb),
        .rvalid    (rvalid),
        .err       (err),
        .busy      (busy)
    );

    initial begin
        clk_65M = 1'b0;
        forever #5 clk_65M = ~clk_65M;
    end

    int cyc = 0;
    always @(posedge clk_65M) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic ok,
                       input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h want %0h",
                     nm, cyc, got, exp);
        end
    endtask

    function automatic logic [0:ROW_W-1] row_of(input logic [ADDR_W-1:0] a);
        logic [0:ROW_W-1] r;
        r = '0;
        for (int k = 0; k < ROW_W/32; k++)
            r[k*32 +: 32] = ({a, 22'(k)} * 32'h9E3779B1) ^ 32'h5A5A0000;
        return r;
    endfunction

    // BRAM: data follows the address by RD_LATENCY cycles
    logic [0:ROW_W-1] pl [RD_LATENCY];
    logic [0:ROW_W-1] pm [RD_LATENCY];
    always @(posedge clk_65M) begin
        pl[0] <= row_of(r_addr_lsb);
        pm[0] <= ~row_of(r_addr_msb);
        for (int k = 1; k < RD_LATENCY; k++) begin
            pl[k] <= pl[k-1];
            pm[k] <= pm[k-1];
        end
    end
    assign r_data_lsb = pl[RD_LATENCY-1];
    assign r_data_msb = pm[RD_LATENCY-1];

    typedef struct {
        int port;
        int addr;
        int due;
    } exp_t;

    exp_t iss_q[$];
    exp_t ret_q[$];
    int   rr_last = NREQ - 1;

    // display first; else the shared port nearest after the last winner
    function automatic int pick(input logic [NREQ-1:0] rq,
                                input logic bl, input logic clr);
        int best, bestd, d;
        logic [NREQ-1:0] el;
        if (clr) return -1;
        for (int i = 0; i < NREQ; i++) el[i] = rq[i] && (!MASK[i] || bl);
        if (el[0]) return 0;
        best  = -1;
        bestd = NREQ;
        for (int p = 1; p < NREQ; p++) begin
            d = (p - rr_last - 1 + 2*(NREQ-1)) % (NREQ-1);
            if (el[p] && d < bestd) begin
                best  = p;
                bestd = d;
            end
        end
        return best;
    endfunction

    task automatic step(input logic [NREQ-1:0] rq,
                        input logic [NREQ*ADDR_W-1:0] ra,
                        input logic bl, input logic clr,
                        output logic [NREQ-1:0] g, output int won);
        logic [NREQ-1:0] eg;
        int a;
        req      = rq;
        req_addr = ra;
        blank    = bl;
        if (clr) begin
            iss_q.delete();
            ret_q.delete();
            rr_last = NREQ - 1;
        end
        clear = clr;
        @(negedge clk_65M);
        won = pick(rq, bl, clr);
        eg  = (won < 0) ? '0 : NREQ'(1) << won;
        g   = gnt;
        chk("gnt", gnt == eg, 64'(gnt), 64'(eg));
        if (won >= 0) begin
            a = int'(ra[won*ADDR_W +: ADDR_W]);
            iss_q.push_back('{port: won, addr: a, due: cyc + 1});
            ret_q.push_back('{port: won, addr: a,
                              due: cyc + 2 + RD_LATENCY});
            if (won != 0) rr_last = won;
        end
        if (clr) begin
            chk("reset_raddr", r_addr_lsb == 0 && r_addr_msb == 0,
                64'(r_addr_lsb), 64'd0);
            chk("reset_rdata", rdata_lsb == '0 && rdata_msb == '0,
                rdata_lsb[0:63], 64'd0);
        end
        @(posedge clk_65M);
        #1;
    endtask

    function automatic logic [NREQ*ADDR_W-1:0] mk(input int a0,
                                                  input int a1,
                                                  input int a2);
        return {ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        if ($urandom_range(0, 9) == 0)
            return ADDR_W'($urandom_range(ROWS, 1023));
        return ADDR_W'($urandom_range(0, ROWS - 1));
    endfunction

    // monitor: issue, return and busy against the scoreboard queues
    always @(negedge clk_65M) begin
        exp_t e;
        logic oor, bz;
        logic [0:ROW_W-1] el, em;
        if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
            e = iss_q.pop_front();
            chk("r_addr_lsb", r_addr_lsb == ADDR_W'(e.addr),
                64'(r_addr_lsb), 64'(e.addr));
            chk("r_addr_msb", r_addr_msb == ADDR_W'(e.addr),
                64'(r_addr_msb), 64'(e.addr));
            chk("rd_en", rd_en == (e.addr < ROWS),
                64'(rd_en), 64'(e.addr < ROWS));
        end else begin
            chk("rd_en_idle", rd_en == 1'b0, 64'(rd_en), 64'd0);
        end
        if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            e   = ret_q.pop_front();
            oor = e.addr >= ROWS;
            el  = oor ? '0 : row_of(ADDR_W'(e.addr));
            em  = oor ? '0 : ~row_of(ADDR_W'(e.addr));
            chk("rvalid", rvalid == (NREQ'(1) << e.port),
                64'(rvalid), 64'(NREQ'(1) << e.port));
            chk("err", err == oor, 64'(err), 64'(oor));
            chk("rdata_lsb", rdata_lsb == el, rdata_lsb[0:63], el[0:63]);
            chk("rdata_msb", rdata_msb == em, rdata_msb[0:63], em[0:63]);
        end else begin
            chk("rvalid_idle", rvalid == '0 && err == 1'b0,
                64'({err, rvalid}), 64'd0);
        end
        bz = 1'b0;
        foreach (ret_q[i])
            if (ret_q[i].due - 1 - RD_LATENCY <= cyc &&
                cyc <= ret_q[i].due - 1) bz = 1'b1;
        chk("busy", busy == bz, 64'(busy), 64'(bz));
    end

    initial begin
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] pend;
        logic [NREQ*ADDR_W-1:0] paddr;
        logic bl, clr;
        int won;
        int seq [7] = '{1, 2, 1, 0, 2, 1, 2};

        clear    = 1'b1;
        blank    = 1'b0;
        req      = '0;
        req_addr = '0;
        @(posedge clk_65M);
        #1;

        repeat (4) step(NREQ'($urandom), {$urandom, $urandom}, 1'b1,
                        1'b1, g, won);
        step(3'b110, mk(0, 10, 20), 1'b1, 1'b0, g, won);
        chk("first_rr", g == 3'b010, 64'(g), 64'h2);
        repeat (6) step('0, '0, 1'b1, 1'b0, g, won);

        step(3'b010, mk(0, 398, 0), 1'b1, 1'b0, g, won);
        chk("single_gnt", g == 3'b010, 64'(g), 64'h2);
        repeat (6) step('0, '0, 1'b1, 1'b0, g, won);

        step('0, '0, 1'b1, 1'b1, g, won);
        for (int c = 0; c < 7; c++) begin
            step((c == 3) ? 3'b111 : 3'b110,
                 mk(100 + c, 200 + c, 300 + c), 1'b1, 1'b0, g, won);
            chk("contention", g == (NREQ'(1) << seq[c]),
                64'(g), 64'(NREQ'(1) << seq[c]));
        end
        repeat (6) step('0, '0, 1'b1, 1'b0, g, won);

        for (int c = 0; c < 3; c++) begin
            step(3'b011, mk(40 + c, 60, 0), 1'b0, 1'b0, g, won);
            chk("mask_disp", g == 3'b001, 64'(g), 64'h1);
        end
        repeat (2) begin
            step(3'b010, mk(0, 60, 0), 1'b0, 1'b0, g, won);
            chk("mask_hold", g == 3'b000, 64'(g), 64'h0);
        end
        step(3'b010, mk(0, 60, 0), 1'b1, 1'b0, g, won);
        chk("mask_open", g == 3'b010, 64'(g), 64'h2);
        repeat (6) step('0, '0, 1'b1, 1'b0, g, won);

        step(3'b100, mk(0, 0, 800), 1'b1, 1'b0, g, won);
        chk("oor_gnt", g == 3'b100, 64'(g), 64'h4);
        repeat (6) step('0, '0, 1'b1, 1'b0, g, won);

        step(3'b010, mk(0, 55, 0), 1'b1, 1'b0, g, won);
        step('0, '0, 1'b1, 1'b0, g, won);
        step('0, '0, 1'b1, 1'b1, g, won);
        repeat (5) step('0, '0, 1'b1, 1'b0, g, won);
        step(3'b010, mk(0, 77, 0), 1'b1, 1'b0, g, won);
        chk("post_clear", g == 3'b010, 64'(g), 64'h2);
        repeat (6) step('0, '0, 1'b1, 1'b0, g, won);

        pend  = '0;
        paddr = '0;
        bl    = 1'b1;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] &&
                    $urandom_range(0, 99) < ((i == 0) ? 15 : 45)) begin
                    pend[i] = 1'b1;
                    paddr[i*ADDR_W +: ADDR_W] = rand_addr();
                end
            end
            if ($urandom_range(0, 15) == 0) bl = ~bl;
            clr = ($urandom_range(0, 249) == 0);
            step(pend, paddr, bl, clr, g, won);
            if (won >= 0) pend[won] = 1'b0;
        end
        repeat (8) step('0, '0, 1'b1, 1'b0, g, won);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/row_read_arbiter.md
# row_read_arbiter

Shares the single read port of the 1024-bit-wide LSB/MSB row BRAM pair between several requesters: display scan, player probe reads (rows above and below the player) and the red-line shader. The arbiter sits between the requesters and the BRAM address/data pins on `clk_65M`. It issues at most one row read per cycle and tags each read in flight. It routes the returned row back to the requester that issued it, after a fixed latency.

## Interface
- `NREQ`, 3, number of requesters. Port 0 is display and has fixed top priority; ports 1..NREQ-1 share by round robin.
- `ADDR_W`, 10, row address width.
- `ROW_W`, 1024, row data width.
- `ROWS`, 768, valid row count; addresses >= ROWS are out of range.
- `RD_LATENCY`, 2, cycles from `r_addr_*` change to valid `r_data_*`. Legal range 1..4.
- `BLANK_MASK`, 3'b110, bit i=1 means port i is granted only while `blank`=1.

Ports:
- `clk_65M`  in  1  system pixel clock; the only clock.
- `clear`  in  1  reset; asynchronous, active-high.
- `blank`  in  1  vertical-blanking indicator from the VGA timing block.
- `req`  in  NREQ  per-port request level.
- `req_addr`  in  NREQ*ADDR_W  per-port row address. Port i occupies bits [i*ADDR_W +: ADDR_W].
- `gnt`  out  NREQ  one-hot, combinational; request consumed this cycle.
- `r_addr_lsb`, `r_addr_msb`  out  ADDR_W  BRAM read address. Both always carry the same value.
- `rd_en`  out  1  BRAM read enable.
- `r_data_lsb`, `r_data_msb`  in  [0:ROW_W-1]  BRAM read data.
- `rdata_lsb`, `rdata_msb`  out  [0:ROW_W-1]  registered return row.
- `rvalid`  out  NREQ  one-hot, one cycle; return row belongs to that port.
- `err`  out  1  pulses with `rvalid` when the returned read was out of range.
- `busy`  out  1  any read in flight.

## Operation
- Request rule:
  - A requester holds `req`=1 with `req_addr` stable until it sees `gnt`.
  - `gnt` consumes the request. If `req` is still 1 in the next cycle, that is a new request, and its address may differ (back-to-back reads).
- Eligibility: port i is eligible when `req[i]`=1 and (`BLANK_MASK[i]`=0 or `blank`=1).
- Priority:
  - An eligible port 0 always wins.
  - Otherwise the winner is the eligible port in 1..NREQ-1 that comes first after `rr_ptr`, in cyclic order.
  - `rr_ptr` updates to the winner only on a grant to ports 1..NREQ-1.
  - `rr_ptr` resets to NREQ-1, so port 1 wins first.
- Issue, on the clock edge that ends the grant cycle:
  - `r_addr_*` <= granted address.
  - `rd_en` <= (addr < ROWS).
  - Tag pipeline stage 0 <= {valid=1, port, oor=(addr >= ROWS)}.
  - When no port is granted: `rd_en` <= 0, stage 0 valid <= 0, and `r_addr_*` holds its value.
- Tag pipeline: RD_LATENCY+1 stages, shifting every cycle.
- Return, at the last stage:
  - `rdata_*` <= `r_data_*`, or all zeros when oor.
  - `rvalid[port]` <= 1.
  - `err` <= oor.
  - When the last stage is not valid, `rvalid` and `err` are 0 and `rdata_*` holds its value.
- `busy` = OR of the valid bits of all tag stages.
- When `blank` falls, reads already in flight still complete; masked ports receive no new grants.

## Timing
- Grant in cycle t → `r_addr_*`/`rd_en` valid in t+1 → `rvalid`/`rdata_*` in t+2+RD_LATENCY. With RD_LATENCY=2 the return is in t+4.
- Throughput is one read per cycle; there is no bubble between back-to-back grants.
- Reset values:
  - All outputs 0; `r_addr_*` = 0.
  - Tag pipeline empty; `rr_ptr` = NREQ-1.
- `clear` asserted mid-flight:
  - All tag stages are cleared immediately and are never returned.
  - No `rvalid` is produced for reads granted before `clear`.
  - `gnt` is forced to 0 while `clear`=1.
- Port 0 can hold off the other ports indefinitely; display issues one request per line, so starvation does not occur in this system.

## Structure
- Shared package `row_bram_pkg` holds:
  - `ADDR_W`, `ROW_W`, `ROWS`.
  - Port index constants `PORT_DISP`=0, `PORT_PLAYER`=1, `PORT_SHADER`=2.
  - The tag struct {valid, port, oor}.
- Sub-module `rr_arbiter` contains the eligible vector, the `rr_ptr` register and the one-hot grant. The port-0 override stays in the top level.

## Test plan
- Reset: with `clear`=1 during random `req` activity, all outputs are 0 and `busy`=0. After `clear` is released, the first grant of port 1 versus port 2 goes to port 1.
- Single read: `blank`=1, port 1 requests address 398 for one cycle t. `gnt[1]`=1 at t, `r_addr_*`=398 at t+1, and `rvalid[1]`=1 at t+4 with `rdata_*` equal to model row 398.
- Contention: `blank`=1, ports 1 and 2 request continuously, and port 0 requests only in cycle 3. Grant sequence is 1,2,1,0,2,1,2; `rvalid` follows the same sequence 4 cycles later.
- Blank mask: `blank`=0 with port 1 and port 0 requesting. Only port 0 is granted. Port 1 is granted in the first cycle `blank`=1.
- Out of range: port 2 requests address 800. `rd_en`=0 at t+1; at t+4 `rvalid[2]`=1, `err`=1 and `rdata_*` all zero.
- Reset mid-flight: port 1 is granted at t and `clear` pulses at t+2. No `rvalid` appears, `busy` drops to 0 with `clear`, and the next request after release is served normally.
